// File: rtl/cram_arb_pkg.sv
// Shared types and constants for the CRAM port arbiter: FSM state encoding and latched command.
package cram_arb_pkg;

    localparam int unsigned CRAM_DATA_W = 16;
    localparam int unsigned CRAM_ADDR_W = 22;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } cram_state_e;

    typedef struct packed {
        logic                   we;
        logic [CRAM_ADDR_W-1:0] addr;
        logic [CRAM_DATA_W-1:0] wdata;
        logic [1:0]             be;
    } cram_cmd_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin winner select: search starts at last_grant+1 and wraps.
// CRAM_ARB_BRIDGE_PRIORITY_EN: requester 0 wins whenever valid; rotation covers 1..NUM_REQ-1.
module rr_picker #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   grant,
    output logic               any_valid
);

`ifdef CRAM_ARB_BRIDGE_PRIORITY_EN
    localparam int RR_LO = 1;
`else
    localparam int RR_LO = 0;
`endif

    logic             found_hi;
    logic [IDX_W-1:0] pick_hi;
    logic [IDX_W-1:0] pick_lo;

    always_comb begin
        found_hi = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        // Descending scan: pick_hi ends as the lowest valid index above last_grant,
        // pick_lo as the lowest valid index overall (the wrap-around candidate).
        for (int i = int'(NUM_REQ) - 1; i >= RR_LO; i--) begin
            if (valid[i]) begin
                if (IDX_W'(i) > last_grant) begin
                    found_hi = 1'b1;
                    pick_hi  = IDX_W'(i);
                end
                pick_lo = IDX_W'(i);
            end
        end
        grant = found_hi ? pick_hi : pick_lo;
`ifdef CRAM_ARB_BRIDGE_PRIORITY_EN
        if (valid[0]) begin
            grant = '0;
        end
`endif
        any_valid = |valid;
    end

endmodule

// File: rtl/cram_arbiter.sv
// Shares one CRAM controller port among NUM_REQ requesters, one transaction at a time.
// Build option CRAM_ARB_BRIDGE_PRIORITY_EN gives requester 0 (bridge ROM loader) strict priority.
module cram_arbiter
    import cram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 22
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0]                req_we,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]    req_addr,
    input  logic [CRAM_DATA_W-1:0]            req_wdata,
    input  logic [NUM_REQ-1:0][1:0]           req_be,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [CRAM_DATA_W-1:0]            rsp_rdata,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic [CRAM_DATA_W-1:0]            mem_wdata,
    output logic [1:0]                        mem_be,
    input  logic                              mem_ack,
    input  logic [CRAM_DATA_W-1:0]            mem_rdata,
    input  logic                              mem_done
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    cram_state_e            state_q, state_d;
    cram_cmd_t              cmd_q, cmd_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [CRAM_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [IDX_W-1:0]       grant;
    logic                   any_valid;
    logic                   accept;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .any_valid  (any_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    // last_grant doubles as the owner of the in-flight transaction.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = ISSUE;
                    last_grant_d = grant;
                    cmd_d.we     = req_we[grant];
                    cmd_d.addr   = CRAM_ADDR_W'(req_addr[grant]);
                    cmd_d.wdata  = req_wdata;
                    cmd_d.be     = req_be[grant];
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_done) begin
                    state_d                   = IDLE;
                    rsp_valid_d[last_grant_q] = 1'b1;
                    rsp_rdata_d               = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The IDLE cycle carrying a response pulse never accepts; arbitration waits one cycle.
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        if ((state_q == IDLE) && !reset && any_valid && (rsp_valid_q == '0)) begin
            accept           = 1'b1;
            req_ready[grant] = 1'b1;
        end
        mem_req   = (state_q == ISSUE);
        mem_we    = cmd_q.we;
        mem_addr  = ADDR_W'(cmd_q.addr);
        mem_wdata = cmd_q.wdata;
        mem_be    = cmd_q.be;
        rsp_valid = rsp_valid_q;
        rsp_rdata = rsp_rdata_q;
    end

endmodule
